// File: rtl/timer_pkg.sv
// Shared definitions for the memory-mapped countdown timer: register offsets,
// CTRL field layout, mode codes and the FSM state encoding.
package timer_pkg;

  localparam logic [1:0] ADDR_CTRL   = 2'd0;
  localparam logic [1:0] ADDR_PRESET = 2'd1;
  localparam logic [1:0] ADDR_COUNT  = 2'd2;

  localparam int CTRL_EN = 0;
  localparam int CTRL_IM = 3;

  localparam logic [1:0] MODE_ONESHOT = 2'b00;
  localparam logic [1:0] MODE_RELOAD  = 2'b01;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_CNT  = 2'd2,
    ST_INT  = 2'd3
  } timer_state_e;

  // Field order matches the CTRL word, so din[3:0] casts straight onto it.
  typedef struct packed {
    logic       im;
    logic [1:0] mode;
    logic       en;
  } ctrl_t;

  // Observable FSM status, kept as one register so checkers can bind to it.
  typedef struct packed {
    timer_state_e state;
    logic         irq_flag;
  } status_t;

  localparam ctrl_t CTRL_RST = '{im: 1'b0, mode: MODE_ONESHOT, en: 1'b0};

  // Only code 01 reloads; 10 and 11 fall back to one-shot.
  function automatic logic is_reload(input ctrl_t c);
    return c.mode == MODE_RELOAD;
  endfunction

endpackage

// File: rtl/timer_device.sv
// Countdown timer on the CPU device bus: CTRL/PRESET/COUNT registers, a
// four-state IDLE/LOAD/CNT/INT controller and a maskable interrupt output.
module timer_device
  import timer_pkg::*;
#(
  parameter logic [31:0] PRESET_RST = 32'd0,
  parameter int          CNT_W      = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sel,
  input  logic        we,
  input  logic [1:0]  addr,
  input  logic [31:0] din,
  output logic [31:0] dout,
  output logic        irq
);

  // Bus access: sel+we is a single-cycle write strobe committed on the next
  // rising edge; reads are combinational on addr and never stall.
  logic wr_ctrl;
  logic wr_preset;

  ctrl_t            ctrl_q,  ctrl_d;
  logic [CNT_W-1:0] preset_q;
  logic [CNT_W-1:0] count_q, count_d;
  status_t          status_q, status_d;

  assign wr_ctrl   = sel && we && (addr == ADDR_CTRL);
  assign wr_preset = sel && we && (addr == ADDR_PRESET);

  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl_q   <= CTRL_RST;
      preset_q <= PRESET_RST[CNT_W-1:0];
      count_q  <= '0;
      status_q <= '{state: ST_IDLE, irq_flag: 1'b0};
    end else begin
      ctrl_q   <= ctrl_d;
      count_q  <= count_d;
      status_q <= status_d;
      if (wr_preset) begin
        preset_q <= din[CNT_W-1:0];
      end
    end
  end

  // All FSM decisions look at ctrl_q, the value before any write this cycle.
  always_comb begin
    ctrl_d   = ctrl_q;
    count_d  = count_q;
    status_d = status_q;

    if (wr_ctrl) begin
      ctrl_d = ctrl_t'(din[CTRL_IM:CTRL_EN]);
    end

    unique case (status_q.state)
      ST_IDLE: begin
        if (ctrl_q.en) begin
          status_d.state = ST_LOAD;
        end
      end
      ST_LOAD: begin
        count_d        = preset_q;
        status_d.state = ST_CNT;
      end
      ST_CNT: begin
        if (!ctrl_q.en) begin
          status_d.state = ST_IDLE;
        end else if (count_q <= CNT_W'(1)) begin
          count_d           = '0;
          status_d.state    = ST_INT;
          status_d.irq_flag = 1'b1;
        end else begin
          count_d = count_q - CNT_W'(1);
        end
      end
      ST_INT: begin
        if (is_reload(ctrl_q)) begin
          status_d.irq_flag = 1'b0;
          status_d.state    = ST_LOAD;
        end else begin
          status_d.state = ST_IDLE;
          // A simultaneous CTRL write keeps its own EN, restarting the timer.
          if (!wr_ctrl) begin
            ctrl_d.en = 1'b0;
          end
        end
      end
      default: begin
        status_d.state = ST_IDLE;
      end
    endcase

    // Software acknowledge overrides a flag being set on the same edge.
    if (wr_ctrl || wr_preset) begin
      status_d.irq_flag = 1'b0;
    end
  end

  always_comb begin
    dout = '0;
    unique case (addr)
      ADDR_CTRL:   dout[CTRL_IM:CTRL_EN] = ctrl_q;
      ADDR_PRESET: dout = 32'(preset_q);
      ADDR_COUNT:  dout = 32'(count_q);
      default:     dout = '0;
    endcase
  end

  assign irq = status_q.irq_flag && ctrl_q.im;

endmodule

// File: tb/tb_timer_device.sv
// Self-checking bench for timer_device: expected values are queued as
// stimulus is issued and popped when the bus/irq outputs are sampled.
module tb_timer_device;
  import timer_pkg::*;

  localparam logic [31:0] RST_PRESET = 32'h0000_0040;

  logic        clk;
  logic        reset;
  logic        sel;
  logic        we;
  logic [1:0]  addr;
  logic [31:0] din;
  logic [31:0] dout;
  logic        irq;

  logic [31:0] exp_q[$];
  int          n_cmp;
  int          n_err;

  timer_device #(
    .PRESET_RST(RST_PRESET),
    .CNT_W     (32)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .sel  (sel),
    .we   (we),
    .addr (addr),
    .din  (din),
    .dout (dout),
    .irq  (irq)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no end expected end");
    $fatal(1);
  end

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks (one clock slot each) ----------------
  // Inputs change on the falling edge; outputs are sampled 1ns later.
  task automatic drive(input logic s, input logic w, input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    reset = 1'b0;
    sel   = s;
    we    = w;
    addr  = a;
    din   = d;
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    drive(1'b1, 1'b1, a, d);
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 1'b0, ADDR_CTRL, 32'd0);
  endtask

  task automatic tick_irq(input string tag);
    drive(1'b0, 1'b0, ADDR_CTRL, 32'd0);
    check(tag, {31'd0, irq}, exp_q.pop_front());
  endtask

  task automatic tick_rd(input string tag, input logic [1:0] a);
    drive(1'b1, 1'b0, a, 32'd0);
    check(tag, dout, exp_q.pop_front());
  endtask

  task automatic tick_cnt_irq(input string tag);
    drive(1'b1, 1'b0, ADDR_COUNT, 32'd0);
    check({tag, "_cnt"}, dout, exp_q.pop_front());
    check({tag, "_irq"}, {31'd0, irq}, exp_q.pop_front());
  endtask

  task automatic rd(input string tag, input logic [1:0] a, input logic [31:0] exp);
    exp_q.push_back(exp);
    tick_rd(tag, a);
  endtask

  // Write while reading the same address: dout must still show the old value.
  task automatic wr_old(input string tag, input logic [1:0] a, input logic [31:0] d,
                        input logic [31:0] exp_old);
    exp_q.push_back(exp_old);
    drive(1'b1, 1'b1, a, d);
    check(tag, dout, exp_q.pop_front());
  endtask

  task automatic push_irq_run(input int zeros, input int ones);
    repeat (zeros) exp_q.push_back(32'd0);
    repeat (ones)  exp_q.push_back(32'd1);
  endtask

  // ---------------- stimulus / scoreboard ----------------
  initial begin
    logic [31:0] reload_cnt[5];
    n_cmp = 0;
    n_err = 0;
    reset = 1'b1;
    sel   = 1'b0;
    we    = 1'b0;
    addr  = 2'd0;
    din   = 32'd0;
    repeat (3) @(negedge clk);

    // Reset values
    rd("rst_ctrl",   ADDR_CTRL,   32'd0);
    rd("rst_preset", ADDR_PRESET, RST_PRESET);
    rd("rst_count",  ADDR_COUNT,  32'd0);
    rd("rst_off3",   2'd3,        32'd0);
    check("rst_irq", {31'd0, irq}, 32'd0);

    // One-shot, N=5, IM=1: irq visible 7 edges after the CTRL write edge
    wr_old("preset_old_value", ADDR_PRESET, 32'd5, RST_PRESET);
    wr(ADDR_CTRL, 32'h9);
    push_irq_run(7, 2);
    repeat (9) tick_irq("oneshot_irq");
    rd("oneshot_ctrl_en_cleared", ADDR_CTRL, 32'h8);
    check("oneshot_irq_held", {31'd0, irq}, 32'd1);
    wr(ADDR_CTRL, 32'h8);
    push_irq_run(1, 0);
    tick_irq("oneshot_ack");

    // Auto-reload, N=3: COUNT 3,2,1,0,0 with a 1-cycle irq every 5 cycles
    wr(ADDR_PRESET, 32'd3);
    wr(ADDR_CTRL, 32'hB);
    reload_cnt = '{32'd3, 32'd2, 32'd1, 32'd0, 32'd0};
    for (int j = 1; j <= 22; j++) begin
      if (j < 3) begin
        exp_q.push_back(32'd0);
        exp_q.push_back(32'd0);
      end else begin
        exp_q.push_back(reload_cnt[(j - 3) % 5]);
        exp_q.push_back(((j - 3) % 5 == 3) ? 32'd1 : 32'd0);
      end
    end
    repeat (22) tick_cnt_irq("reload");
    wr(ADDR_CTRL, 32'h8);
    idle(6);

    // Masked one-shot: flag sets silently, then CTRL=0x8 clears it
    wr(ADDR_PRESET, 32'd2);
    wr(ADDR_CTRL, 32'h1);
    push_irq_run(8, 0);
    repeat (8) tick_irq("masked_irq");
    rd("masked_ctrl", ADDR_CTRL, 32'h0);
    wr(ADDR_CTRL, 32'h8);
    push_irq_run(3, 0);
    repeat (3) tick_irq("masked_unmask");

    // Stop after 4 CNT cycles, COUNT freezes at 7, then reload from PRESET=2
    wr(ADDR_PRESET, 32'd10);
    wr(ADDR_CTRL, 32'h9);
    idle(2);
    rd("stop_cnt_a", ADDR_COUNT, 32'd10);
    rd("stop_cnt_b", ADDR_COUNT, 32'd9);
    wr(ADDR_CTRL, 32'h8);
    for (int j = 0; j < 4; j++) rd("stop_hold", ADDR_COUNT, 32'd7);
    wr(ADDR_PRESET, 32'd2);
    wr(ADDR_CTRL, 32'h9);
    reload_cnt = '{32'd7, 32'd7, 32'd2, 32'd1, 32'd0};
    for (int j = 0; j < 5; j++) begin
      exp_q.push_back(reload_cnt[j]);
      exp_q.push_back((j == 4) ? 32'd1 : 32'd0);
    end
    repeat (5) tick_cnt_irq("restart");
    wr(ADDR_CTRL, 32'h8);
    push_irq_run(1, 0);
    tick_irq("restart_ack");

    // CTRL write on the edge that would set the flag: clear wins
    wr(ADDR_PRESET, 32'd3);
    wr(ADDR_CTRL, 32'h9);
    push_irq_run(4, 0);
    repeat (4) tick_irq("coll_pre");
    wr(ADDR_CTRL, 32'h8);
    push_irq_run(5, 0);
    repeat (5) tick_irq("coll_set_clear");
    rd("coll_ctrl", ADDR_CTRL, 32'h8);

    // CTRL write with EN=1 during INT: written EN wins, timer restarts
    wr(ADDR_PRESET, 32'd2);
    wr(ADDR_CTRL, 32'h9);
    push_irq_run(4, 0);
    repeat (4) tick_irq("enwin_pre");
    wr(ADDR_CTRL, 32'h9);
    check("enwin_int_irq", {31'd0, irq}, 32'd1);
    push_irq_run(4, 1);
    repeat (5) tick_irq("enwin_restart");
    wr(ADDR_CTRL, 32'h8);

    // Ignored writes and read-zero fields
    wr(ADDR_COUNT, 32'h0000_FFFF);
    rd("count_write_ignored", ADDR_COUNT, 32'd0);
    wr(2'd3, 32'h1234_5678);
    rd("off3_reads_zero", 2'd3, 32'd0);
    wr(ADDR_CTRL, 32'hFFFF_FFF8);
    rd("ctrl_upper_ignored", ADDR_CTRL, 32'h8);

    // Reset asserted mid-count
    wr(ADDR_PRESET, 32'd10);
    wr(ADDR_CTRL, 32'h9);
    idle(2);
    rd("midrst_cnt", ADDR_COUNT, 32'd10);
    @(negedge clk);
    reset = 1'b1;
    sel   = 1'b0;
    we    = 1'b0;
    rd("midrst_ctrl",   ADDR_CTRL,   32'd0);
    rd("midrst_preset", ADDR_PRESET, RST_PRESET);
    rd("midrst_count",  ADDR_COUNT,  32'd0);
    check("midrst_irq", {31'd0, irq}, 32'd0);
    push_irq_run(4, 0);
    repeat (4) tick_irq("midrst_stays_idle");

    check("sb_drained", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
